// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port RAM bank with per-byte write enables,
// configurable read latency, read-data valid strobe and optional
// hardware clear after reset.
module ram_bank #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WRITE_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    write_enable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    busy
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_READY,
        ST_CLEAR
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic                  acc_valid;
    logic [DATA_WIDTH-1:0] acc_data;

    logic                  out_valid_in;
    logic [DATA_WIDTH-1:0] out_data_in;

    logic                  data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Old contents at the requested address (read-first) and the word as it
    // will look after a masked write of data_in.
    assign rd_word = mem[address];

    // Merge write data into the current word byte by byte.
    always_comb begin
        merged_word = rd_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (byte_enable[i]) begin
                merged_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Next-state logic: clear sweep, request decode and memory port muxing.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = data_in;
        mem_be    = byte_enable;
        acc_valid = 1'b0;
        acc_data  = rd_word;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                if (enable) begin
                    if (write_enable) begin
                        mem_we = 1'b1;
                        if (WRITE_MODE != 0) begin
                            acc_valid = 1'b1;
                            acc_data  = merged_word;
                        end
                    end else begin
                        acc_valid = 1'b1;
                        acc_data  = rd_word;
                    end
                end
            end
        endcase
    end

    // FSM and clear counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array with per-byte write strobes; never reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_valid_q, s1_valid_d;
            logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

            // Extra pipeline stage in front of the output register.
            always_comb begin
                s1_valid_d = acc_valid;
                s1_data_d  = acc_valid ? acc_data : s1_data_q;
            end

            // Pipeline stage register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                end
            end

            assign out_valid_in = s1_valid_q;
            assign out_data_in  = s1_data_q;
        end else begin : g_lat1
            assign out_valid_in = acc_valid;
            assign out_data_in  = acc_data;
        end
    endgenerate

    // Output register: data_out only changes with a valid strobe.
    always_comb begin
        data_valid_d = out_valid_in;
        data_out_d   = out_valid_in ? out_data_in : data_out_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives two ram_bank instances (latency 1 / no-change and
// latency 2 / write-through) with identical stimulus and checks both against
// a behavioural memory model every cycle.
module tb_ram_bank;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    typedef struct {
        int          due;
        logic [15:0] d;
    } pend_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    byte_enable = '0;

    logic [DW-1:0] dout [2];
    logic          dval [2];
    logic          bsy  [2];

    int checks = 0;
    int failures = 0;

    // behavioural model
    logic [15:0] mem_m [DEPTH];
    int          clear_left = DEPTH;
    int          ecount = 0;
    bit          run = 1'b0;
    pend_t       pq [2][$];
    logic [15:0] hold [2];

    always #5 clk = ~clk;

    ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
               .CLEAR_ON_RESET(1), .WRITE_MODE(0)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
        .address(address), .data_in(data_in), .byte_enable(byte_enable),
        .data_out(dout[0]), .data_valid(dval[0]), .busy(bsy[0]));

    ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
               .CLEAR_ON_RESET(1), .WRITE_MODE(1)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .write_enable(write_enable),
        .address(address), .data_in(data_in), .byte_enable(byte_enable),
        .data_out(dout[1]), .data_valid(dval[1]), .busy(bsy[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Apply one request at a clock edge to the model.
    task automatic model_step(input logic en, input logic we, input logic [3:0] a,
                              input logic [15:0] d, input logic [1:0] be);
        logic [15:0] w;
        if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = 16'h0000;
            clear_left--;
            return;
        end
        if (!en) return;
        if (we) begin
            w = mem_m[a];
            if (be[0]) w[7:0]  = d[7:0];
            if (be[1]) w[15:8] = d[15:8];
            mem_m[a] = w;
            pq[1].push_back('{due: ecount + 1, d: w});
        end else begin
            w = mem_m[a];
            pq[0].push_back('{due: ecount, d: w});
            pq[1].push_back('{due: ecount + 1, d: w});
        end
    endtask

    task automatic cyc(input logic en, input logic we, input logic [3:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        enable       = en;
        write_enable = we;
        address      = a;
        data_in      = d;
        byte_enable  = be;
        @(posedge clk);
        ecount++;
        if (reset) model_step(en, we, a, d, be);
        #1;
        run = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 16'h0, 2'b00);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        clear_left = DEPTH;
        for (int k = 0; k < 2; k++) begin
            pq[k].delete();
            hold[k] = 16'h0000;
        end
    endtask

    // Count cycles that busy stays high after reset release; random requests
    // are issued throughout and must be ignored.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                16'($urandom), 2'($urandom_range(0, 3)));
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                logic expv;
                expv = 1'b0;
                if (pq[k].size() > 0 && pq[k][0].due < ecount) begin
                    chk("stale_pending", 32'(pq[k][0].due), 32'(ecount));
                    void'(pq[k].pop_front());
                end
                if (pq[k].size() > 0 && pq[k][0].due == ecount) begin
                    expv    = 1'b1;
                    hold[k] = pq[k][0].d;
                    void'(pq[k].pop_front());
                end
                chk(k == 0 ? "valid_a" : "valid_b", 32'(dval[k]), 32'(expv));
                chk(k == 0 ? "dout_a" : "dout_b", 32'(dout[k]), 32'(hold[k]));
                chk(k == 0 ? "busy_a" : "busy_b", 32'(bsy[k]), 32'(clear_left > 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        hold[0] = 16'h0000;
        hold[1] = 16'h0000;

        // reset low 3 cycles, then the hardware clear
        idle(3);
        reset = 1'b1;
        count_busy("clear_cycles");
        for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, 4'(a), 16'h0, 2'b00);
        idle(2);
        chk("zero_read_a", 32'(dout[0]), 32'h0000);

        // full write then read
        cyc(1'b1, 1'b1, 4'd5, 16'hA5C3, 2'b11);
        cyc(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        idle(2);
        chk("full_write_a", 32'(dout[0]), 32'hA5C3);
        chk("full_write_b", 32'(dout[1]), 32'hA5C3);

        // partial and empty byte masks
        cyc(1'b1, 1'b1, 4'd5, 16'h1234, 2'b01);
        cyc(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        idle(2);
        chk("low_byte_a", 32'(dout[0]), 32'hA534);
        cyc(1'b1, 1'b1, 4'd5, 16'hFFFF, 2'b00);
        cyc(1'b1, 1'b0, 4'd5, 16'h0, 2'b00);
        idle(2);
        chk("no_byte_a", 32'(dout[0]), 32'hA534);
        chk("no_byte_b", 32'(dout[1]), 32'hA534);

        // back-to-back reads with a write in the middle
        cyc(1'b1, 1'b1, 4'd1, 16'h0011, 2'b11);
        cyc(1'b1, 1'b1, 4'd2, 16'h0022, 2'b11);
        cyc(1'b1, 1'b1, 4'd3, 16'h0033, 2'b11);
        cyc(1'b1, 1'b0, 4'd1, 16'h0, 2'b00);
        cyc(1'b1, 1'b0, 4'd2, 16'h0, 2'b00);
        cyc(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
        cyc(1'b1, 1'b1, 4'd4, 16'hBEEF, 2'b10);
        idle(3);
        chk("wr_nochange_a", 32'(dout[0]), 32'h0033);
        chk("wr_through_b", 32'(dout[1]), 32'hBE00);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(3);

        // reset at clear count 7, requests during busy are ignored
        assert_reset();
        idle(2);
        reset = 1'b1;
        for (int i = 0; i < 7; i++)
            cyc(1'b1, 1'b1, 4'($urandom_range(0, 15)), 16'hFFFF, 2'b11);
        assert_reset();
        idle(2);
        reset = 1'b1;
        count_busy("restart_clear_cycles");
        for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, 4'(a), 16'h0, 2'b00);
        idle(2);
        chk("post_restart_zero_b", 32'(dout[1]), 32'h0000);

        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(3);
        run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
